// File: rtl/analog_io_pkg.sv
// rtl/analog_io_pkg.sv - shared types, register map and pad-mode decode for analog_io_sequencer
// Contents: mode_e (per-channel pad mode), state_e (sequencer FSM), REG_* byte offsets,
//           mode_decode() returning {oeb, out} for one pad.
package analog_io_pkg;

   typedef enum logic [1:0] {
      MODE_HIZ  = 2'b00,
      MODE_LOW  = 2'b01,
      MODE_HIGH = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_BREAK  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_APPLY  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   localparam logic [3:0] REG_PENDING = 4'h0;
   localparam logic [3:0] REG_STATUS  = 4'h4;
   localparam logic [3:0] REG_APPLY   = 4'h8;
   localparam logic [3:0] REG_ACTIVE  = 4'hC;

   // Reserved encoding deliberately falls into the HIZ default.
   function automatic logic [1:0] mode_decode(input logic [1:0] mode);
      case (mode)
         MODE_LOW:  mode_decode = 2'b00;
         MODE_HIGH: mode_decode = 2'b01;
         default:   mode_decode = 2'b10;
      endcase
   endfunction

endpackage

// File: rtl/analog_io_sequencer_if.sv
// rtl/analog_io_sequencer_if.sv - Wishbone slave bundle for analog_io_sequencer
// Signals: wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i[3:0], wbs_adr_i[31:0], wbs_dat_i[31:0] (master->slave);
//          wbs_ack_o, wbs_dat_o[31:0] (slave->master).
interface analog_io_sequencer_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/analog_io_wb_regs.sv
// rtl/analog_io_wb_regs.sv - Wishbone decode, ack, register file and readback for analog_io_sequencer
// Ports: clk, rst (async, active-high); wb (slave modport); busy, active (from sequencer);
//        pending (PENDING register), irq_mask (STATUS b2), apply_start (accepted APPLY write pulse).
// Option: ANALOG_IO_SEQ_IRQ_EN adds the RW irq_mask bit at STATUS b2 (reset 1).
module analog_io_wb_regs
   import analog_io_pkg::*;
#(
   parameter int          NUM_CH    = 6,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   analog_io_sequencer_if.slave  wb,
   input  logic                  busy,
   input  logic [2*NUM_CH-1:0]   active,
   output logic [2*NUM_CH-1:0]   pending,
   output logic                  irq_mask,
   output logic                  apply_start
);

   logic                ack_q;
   logic [31:0]         dat_q;
   logic [2*NUM_CH-1:0] pend_q;
   logic                err_q;
   logic                status_b2;
   logic                req;
   logic [1:0]          word;
   logic                wr_apply;
   logic                wr_status;
   logic [31:0]         rdata;
   logic                unused_bits;

   assign word = wb.wbs_adr_i[3:2];

   // The ~ack_q term forces an idle cycle between back-to-back acks.
   assign req = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;

   assign wr_apply    = req & wb.wbs_we_i & (word == REG_APPLY[3:2]) & wb.wbs_sel_i[0] & wb.wbs_dat_i[0];
   assign wr_status   = req & wb.wbs_we_i & (word == REG_STATUS[3:2]) & wb.wbs_sel_i[0];
   assign apply_start = wr_apply & ~busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q  <= 1'b0;
         dat_q  <= '0;
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         ack_q <= req;
         dat_q <= (req & ~wb.wbs_we_i) ? rdata : 32'h0;
         if (req & wb.wbs_we_i & (word == REG_PENDING[3:2])) begin
            for (int i = 0; i < 2*NUM_CH; i++) begin
               if (wb.wbs_sel_i[i/8]) pend_q[i] <= wb.wbs_dat_i[i];
            end
         end
         // A rejected APPLY outranks a simultaneous W1C clear.
         if (wr_apply & busy)
            err_q <= 1'b1;
         else if (wr_status & wb.wbs_dat_i[1])
            err_q <= 1'b0;
      end
   end

`ifdef ANALOG_IO_SEQ_IRQ_EN
   logic mask_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mask_q <= 1'b1;
      else if (wr_status)
         mask_q <= wb.wbs_dat_i[2];
   end
   assign irq_mask  = mask_q;
   assign status_b2 = mask_q;
`else
   assign irq_mask  = 1'b1;
   assign status_b2 = 1'b0;
`endif

   always_comb begin
      rdata = '0;
      case (word)
         REG_PENDING[3:2]: rdata[2*NUM_CH-1:0] = pend_q;
         REG_STATUS[3:2]:  rdata[2:0]          = {status_b2, err_q, busy};
         REG_ACTIVE[3:2]:  rdata[2*NUM_CH-1:0] = active;
         default:          rdata               = '0;
      endcase
   end

   assign pending      = pend_q;
   assign wb.wbs_ack_o = ack_q;
   assign wb.wbs_dat_o = dat_q;

   // Sub-word address bits and data/select bits beyond the register widths are don't-care.
   assign unused_bits = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i, wb.wbs_sel_i};

endmodule

// File: rtl/analog_io_sequencer.sv
// rtl/analog_io_sequencer.sv - break-before-make pad mode sequencer for pins shared with analog_io
// Ports: wb_clk_i, wb_rst_i (async, active-high); wb (Wishbone slave modport);
//        io_oeb[NUM_CH] (active-low enable), io_out[NUM_CH], irq (sequence-done pulse).
// Option: ANALOG_IO_SEQ_IRQ_EN enables irq and the STATUS irq_mask bit; otherwise irq is tied 0.
module analog_io_sequencer
   import analog_io_pkg::*;
#(
   parameter int          NUM_CH        = 6,
   parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
   parameter int          SETTLE_CYCLES = 16
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   analog_io_sequencer_if.slave wb,
   output logic [NUM_CH-1:0]    io_oeb,
   output logic [NUM_CH-1:0]    io_out,
   output logic                 irq
);

   localparam int              CNT_W    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam int              LAST_I   = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [NUM_CH-1:0]   chg_q, chg_d;
   logic [2*NUM_CH-1:0] snap_q;
   logic [2*NUM_CH-1:0] active_q;
   logic [2*NUM_CH-1:0] pending;
   logic                irq_mask;
   logic                apply_start;
   logic                busy;
   logic                force_hiz;

   analog_io_wb_regs #(
      .NUM_CH    (NUM_CH),
      .BASE_ADDR (BASE_ADDR)
   ) u_regs (
      .clk         (wb_clk_i),
      .rst         (wb_rst_i),
      .wb          (wb),
      .busy        (busy),
      .active      (active_q),
      .pending     (pending),
      .irq_mask    (irq_mask),
      .apply_start (apply_start)
   );

   assign busy = (state_q != ST_IDLE);

   always_comb begin
      chg_d = '0;
      for (int i = 0; i < NUM_CH; i++)
         chg_d[i] = (pending[2*i +: 2] != active_q[2*i +: 2]);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Snapshot, settle counter and ACTIVE update.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cnt_q    <= '0;
         chg_q    <= '0;
         snap_q   <= '0;
         active_q <= '0;
      end else begin
         if (apply_start) begin
            chg_q  <= chg_d;
            snap_q <= pending;
         end
         if (state_q == ST_BREAK)
            cnt_q <= '0;
         else if ((state_q == ST_SETTLE) && (cnt_q != CNT_LAST))
            cnt_q <= cnt_q + 1'b1;
         if (state_q == ST_APPLY)
            active_q <= snap_q;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (apply_start) state_d = ST_BREAK;
         ST_BREAK:  state_d = ((chg_q == '0) || (SETTLE_CYCLES == 0)) ? ST_APPLY : ST_SETTLE;
         ST_SETTLE: if (cnt_q == CNT_LAST) state_d = ST_APPLY;
         ST_APPLY:  state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Changing pads stay HIZ from BREAK through APPLY; ACTIVE only updates at the end of APPLY,
   // so new drive first appears in DONE.
   assign force_hiz = (state_q == ST_BREAK) || (state_q == ST_SETTLE) || (state_q == ST_APPLY);

   always_comb begin
      io_oeb = '1;
      io_out = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (force_hiz && chg_q[i])
            {io_oeb[i], io_out[i]} = 2'b10;
         else
            {io_oeb[i], io_out[i]} = mode_decode(active_q[2*i +: 2]);
      end
   end

`ifdef ANALOG_IO_SEQ_IRQ_EN
   assign irq = (state_q == ST_DONE) && !irq_mask;
`else
   logic unused_mask;
   assign unused_mask = irq_mask;
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_analog_io_sequencer.sv
// tb/tb_analog_io_sequencer.sv - scoreboard bench for analog_io_sequencer
module tb_analog_io_sequencer;

   localparam int          NUM_CH = 6;
   localparam int          SETTLE = 16;
   localparam logic [31:0] BASE   = 32'h3000_0000;
   localparam logic [31:0] PMASK  = (32'h1 << (2*NUM_CH)) - 1;
`ifdef ANALOG_IO_SEQ_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic [NUM_CH-1:0] io_oeb;
   logic [NUM_CH-1:0] io_out;
   logic              irq;

   analog_io_sequencer_if wbi();

   analog_io_sequencer #(
      .NUM_CH(NUM_CH), .BASE_ADDR(BASE), .SETTLE_CYCLES(SETTLE)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb       (wbi),
      .io_oeb   (io_oeb),
      .io_out   (io_out),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Reference model: registers as plain words, pad behaviour from the mode table.
   logic [31:0] m_pend_w;
   logic [31:0] m_active_w;
   bit          m_err;
   bit          m_mask;

   typedef struct {
      bit          is_read;
      logic [31:0] exp;
      string       name;
   } sb_t;
   sb_t sbq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [2*NUM_CH-1:0] pads_of(input logic [31:0] modes, input logic [NUM_CH-1:0] hiz);
      logic [NUM_CH-1:0] oeb, out;
      int m;
      for (int c = 0; c < NUM_CH; c++) begin
         m = int'((modes >> (2*c)) & 32'h3);
         oeb[c] = !(m == 1 || m == 2) || hiz[c];
         out[c] = (m == 2) && !hiz[c];
      end
      return {oeb, out};
   endfunction

   function automatic logic [31:0] status_exp(input bit busy);
      return {29'b0, (IRQ_EN && m_mask), m_err, busy};
   endfunction

   // Monitor: every ack consumes one scoreboard entry; reads compare data.
   always @(negedge clk) begin
      sb_t e;
      if (wbi.wbs_ack_o === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_ack actual=1 required=0");
         end else begin
            e = sbq.pop_front();
            if (e.is_read) check(e.name, wbi.wbs_dat_o, e.exp);
         end
      end
   end

   task automatic xfer(input bit we, input logic [3:0] off, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp, input string name);
      sb_t e;
      int  n;
      @(negedge clk);
      e.is_read = !we;
      e.exp     = exp;
      e.name    = name;
      sbq.push_back(e);
      wbi.wbs_cyc_i = 1'b1;
      wbi.wbs_stb_i = 1'b1;
      wbi.wbs_we_i  = we;
      wbi.wbs_sel_i = sel;
      wbi.wbs_adr_i = BASE | {28'h0, off};
      wbi.wbs_dat_i = dat;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (wbi.wbs_ack_o !== 1'b1 && n < 20);
      if (wbi.wbs_ack_o !== 1'b1) begin
         checks++;
         fails++;
         $display("FAIL %s_ack_timeout actual=no_ack required=ack", name);
         void'(sbq.pop_back());
      end
      wbi.wbs_cyc_i = 1'b0;
      wbi.wbs_stb_i = 1'b0;
      wbi.wbs_we_i  = 1'b0;
   endtask

   task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string name);
      xfer(1'b0, off, 32'h0, 4'hF, exp, name);
   endtask

   task automatic wr_pending(input logic [31:0] dat, input logic [3:0] sel, input string name);
      xfer(1'b1, 4'h0, dat, sel, 32'h0, name);
      for (int b = 0; b < 4; b++)
         if (sel[b]) m_pend_w[8*b +: 8] = dat[8*b +: 8];
      m_pend_w &= PMASK;
   endtask

   task automatic wr_status(input logic [31:0] dat, input string name);
      xfer(1'b1, 4'h4, dat, 4'hF, 32'h0, name);
      if (dat[1]) m_err = 1'b0;
      if (IRQ_EN) m_mask = dat[2];
   endtask

   // Full apply with a per-cycle pad/irq check across BREAK, SETTLE, APPLY and DONE.
   task automatic apply_seq(input string name);
      logic [31:0]       old_w, new_w;
      logic [NUM_CH-1:0] chg;
      int                len;
      old_w = m_active_w;
      new_w = m_pend_w;
      for (int c = 0; c < NUM_CH; c++)
         chg[c] = ((old_w >> (2*c)) & 32'h3) != ((new_w >> (2*c)) & 32'h3);
      len = (chg == '0 || SETTLE == 0) ? 2 : SETTLE + 2;
      xfer(1'b1, 4'h8, 32'h1, 4'hF, 32'h0, {name, "_apply"});
      for (int k = 0; k <= len; k++) begin
         @(negedge clk);
         check($sformatf("%s_pads_k%0d", name, k), {20'h0, io_oeb, io_out},
               {20'h0, (k < len) ? pads_of(old_w, chg) : pads_of(new_w, '0)});
         check($sformatf("%s_irq_k%0d", name, k), {31'h0, irq},
               {31'h0, (IRQ_EN && !m_mask && k == len)});
      end
      m_active_w = new_w;
      rd(4'hC, m_active_w, {name, "_active"});
      rd(4'h4, status_exp(1'b0), {name, "_status"});
   endtask

   initial begin
      logic [31:0] snap, d;
      int          acks;
      wbi.wbs_cyc_i = 1'b0;
      wbi.wbs_stb_i = 1'b0;
      wbi.wbs_we_i  = 1'b0;
      wbi.wbs_sel_i = 4'h0;
      wbi.wbs_adr_i = 32'h0;
      wbi.wbs_dat_i = 32'h0;
      m_pend_w = 0; m_active_w = 0; m_err = 0; m_mask = 1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("reset_oeb", {26'h0, io_oeb}, 32'h3F);
      check("reset_out", {26'h0, io_out}, 32'h0);
      check("reset_irq", {31'h0, irq}, 32'h0);
      rd(4'hC, 32'h0, "reset_active");
      rd(4'h4, status_exp(1'b0), "reset_status");
      rd(4'h0, 32'h0, "reset_pending");

      // Unmapped window just above the block: must never be acked.
      @(negedge clk);
      wbi.wbs_cyc_i = 1'b1; wbi.wbs_stb_i = 1'b1; wbi.wbs_adr_i = BASE + 32'h10;
      acks = 0;
      repeat (4) begin @(negedge clk); if (wbi.wbs_ack_o === 1'b1) acks++; end
      wbi.wbs_cyc_i = 1'b0; wbi.wbs_stb_i = 1'b0;
      check("no_hit_ack_count", acks, 0);

      wr_pending(32'h9, 4'hF, "p_09");
      apply_seq("seq_09");
      check("seq_09_oeb", {26'h0, io_oeb}, 32'h3C);
      check("seq_09_out", {26'h0, io_out}, 32'h02);

      wr_pending(32'h5, 4'hF, "p_05");
      apply_seq("seq_05");

      // Byte selects: only bits 11:8 may change.
      wr_pending(32'hFFF, 4'h2, "p_sel2");
      rd(4'h0, m_pend_w, "pending_sel2");
      apply_seq("seq_sel2");

      for (int it = 0; it < 5; it++) begin
         wr_pending($urandom, 4'($urandom_range(1, 15)), $sformatf("p_rnd%0d", it));
         rd(4'h0, m_pend_w, $sformatf("pending_rnd%0d", it));
         apply_seq($sformatf("seq_rnd%0d", it));
      end

      // APPLY while busy is rejected; the PENDING write during busy is kept for later.
      wr_pending(m_active_w ^ 32'h3, 4'hF, "p_err_a");
      snap = m_pend_w;
      xfer(1'b1, 4'h8, 32'h1, 4'hF, 32'h0, "err_apply1");
      wr_pending(32'hAAA, 4'hF, "p_err_b");
      xfer(1'b1, 4'h8, 32'h1, 4'hF, 32'h0, "err_apply2");
      m_err = 1'b1;
      rd(4'h4, status_exp(1'b1), "err_status_busy");
      repeat (SETTLE + 10) @(negedge clk);
      m_active_w = snap;
      check("err_pads", {20'h0, io_oeb, io_out}, {20'h0, pads_of(m_active_w, '0)});
      rd(4'hC, m_active_w, "err_active_snapshot");
      rd(4'h4, status_exp(1'b0), "err_status_idle");
      wr_status(32'h2 | ({31'h0, m_mask} << 2), "err_clear");
      rd(4'h4, status_exp(1'b0), "err_status_cleared");
      apply_seq("seq_after_err");

      // Asynchronous reset in the middle of SETTLE.
      wr_pending(m_active_w ^ 32'h1, 4'hF, "p_rst");
      xfer(1'b1, 4'h8, 32'h1, 4'hF, 32'h0, "rst_apply");
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_oeb", {26'h0, io_oeb}, 32'h3F);
      check("rst_async_out", {26'h0, io_out}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      m_pend_w = 0; m_active_w = 0; m_err = 0; m_mask = 1;
      rd(4'hC, 32'h0, "post_rst_active");
      rd(4'h4, status_exp(1'b0), "post_rst_status");

      // No-change apply: nothing goes HIZ; irq pulses when enabled and unmasked.
      wr_pending(32'h6, 4'hF, "p_nc_setup");
      apply_seq("seq_nc_setup");
      if (IRQ_EN) wr_status(32'h0, "unmask");
      d = m_active_w;
      wr_pending(d, 4'hF, "p_nochange");
      apply_seq("seq_nochange");

      begin
         int n = 0;
         while (sbq.size() != 0 && n < 50) begin @(negedge clk); n++; end
         if (sbq.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
